// File: rtl/cap_comp_loss_buffer.sv
// rtl/cap_comp_loss_buffer.sv - precision-loss detect, tag drop, FIFO and saturating stats after the capability compressor
module cap_comp_loss_buffer #(
  parameter int DEPTH            = 2,
  parameter int CNT_W            = 32,
  parameter bit DROP_TAG_ON_LOSS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [128:0]     in_cap,
  input  logic             in_comp_en,
  input  logic [9:0]       in_lost_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128:0]     out_cap,
  output logic             out_loss,
  input  logic             stats_clear,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_comp,
  output logic [CNT_W-1:0] cnt_loss
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

  logic [128:0]   mem_cap [DEPTH];
  logic           mem_loss [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           push, pop, loss;
  logic [128:0]   store_cap;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign loss      = in_comp_en & (|in_lost_bits);
  assign store_cap = {in_cap[128] & ~(loss & DROP_TAG_ON_LOSS), in_cap[127:0]};

  // Head is masked while empty so stale storage never leaks onto out_cap.
  assign out_cap  = out_valid ? mem_cap[rd_ptr]  : '0;
  assign out_loss = out_valid ? mem_loss[rd_ptr] : 1'b0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && !(&c)) ? c + STAT_ONE : c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_cap[wr_ptr]  <= store_cap;
      mem_loss[wr_ptr] <= loss;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_total <= '0;
      cnt_comp  <= '0;
      cnt_loss  <= '0;
    end else if (stats_clear) begin
      cnt_total <= '0;
      cnt_comp  <= '0;
      cnt_loss  <= '0;
    end else begin
      cnt_total <= sat_inc(cnt_total, push);
      cnt_comp  <= sat_inc(cnt_comp, push & in_comp_en);
      cnt_loss  <= sat_inc(cnt_loss, push & loss);
    end
  end

endmodule

// File: doc/cap_comp_loss_buffer.md
Name: cap_comp_loss_buffer

Overview:
- Stage directly downstream of the 129-bit capability compressor. Accepts each compressed capability together with the 10 low payload bits the compressor masked off, and detects precision loss.
- When DROP_TAG_ON_LOSS is set, clears the tag of any lossy capability.
- Buffers results in a small FIFO with valid/ready handshakes, and keeps saturating statistics counters for the CPI/capwidth study.

Parameters:
DEPTH, 2, FIFO entries; power of two, >=2
CNT_W, 32, width of each statistics counter
DROP_TAG_ON_LOSS, 1, 1 = clear bit 128 of lossy capabilities on output; 0 = pass tag unchanged

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream capability valid
in_ready  output  1  stage can accept
in_cap  input  129  compressed capability; bit 128 = tag, [127:0] = payload
in_comp_en  input  1  compressor enable_comp for this capability
in_lost_bits  input  10  original payload bits [9:0] before masking
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts
out_cap  output  129  capability, tag possibly cleared
out_loss  output  1  head entry lost precision
stats_clear  input  1  synchronous clear of all counters
cnt_total  output  CNT_W  capabilities accepted
cnt_comp  output  CNT_W  accepted with in_comp_en=1
cnt_loss  output  CNT_W  accepted lossy capabilities

Behaviour:
- Loss rule: loss = in_comp_en & (in_lost_bits != 0). With in_comp_en=0, loss=0 regardless of in_lost_bits.
- Stored capability: in_cap[127:0] is stored unchanged. Tag is stored as in_cap[128] & ~(loss & DROP_TAG_ON_LOSS). out_loss is stored with the entry.
- Handshakes:
  - Accept when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - in_ready = (count != DEPTH), from registered state only; there is no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_cap and out_loss come from the head entry and hold stable while out_valid & ~out_ready.
- Latency: an accepted capability appears on out_* the cycle after acceptance at the earliest. There is no same-cycle bypass.
- FIFO:
  - Write pointer and read pointer are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance.
  - When full, push is impossible (in_ready=0), even if a pop occurs that cycle.
  - When empty, pop is impossible (out_valid=0).
- Counters:
  - On accept, cnt_total += 1; cnt_comp += in_comp_en; cnt_loss += loss.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
  - stats_clear has priority: all counters become 0 next cycle, and a capability accepted in the same cycle is not counted. The FIFO is unaffected by stats_clear.
- Reset:
  - Asynchronous assertion forces count=0, pointers=0, all counters=0. Therefore in_ready=1, out_valid=0, out_loss=0.
  - out_cap is 0 on reset; storage need not be reset, but out_cap is masked to 0 when empty.
  - Reset mid-transfer discards all buffered entries; nothing is replayed.
- Invariants: cnt_loss <= cnt_comp <= cnt_total while no counter is saturated. Output order equals input order.

Test Plan:
- Reset released, idle -> in_ready=1, out_valid=0, out_cap=0, all counters 0.
- Push cap tag=1, payload 0x...0400, comp_en=1, lost_bits=0 -> next cycle out_valid=1, out_loss=0, tag=1; counters total=1, comp=1, loss=0.
- Push tag=1, comp_en=1, lost_bits=0x3FF, DROP_TAG_ON_LOSS=1 -> out_cap[128]=0, out_loss=1, cnt_loss=1. Same with DROP_TAG_ON_LOSS=0 -> tag stays 1.
- Push comp_en=0, lost_bits=0x155 -> out_loss=0, cnt_comp unchanged, cnt_total+1.
- Hold out_ready=0 and push 3 caps A,B,C with DEPTH=2 -> in_ready drops after B, C waits; out_cap holds A stable. Then out_ready=1 -> A, B, C drain in order, and in_ready rises the cycle after the first pop.
- Preload counters near saturation (CNT_W=4, 15 accepts) then 1 more -> cnt_total stays 15.
- Assert stats_clear together with an accept -> counters 0 next cycle, and the entry still appears on out_*.
- Assert rst asynchronously with 2 entries buffered -> out_valid=0 immediately.
